// File: rtl/ex_if.sv
// ex_if: ID->EX->MEM bus bundle for the execute stage.
//   id_to_ex_bus    171-bit decoded instruction bus from ID
//   br_e / br_addr  branch/jump resolution returned to ID
//   stallreq_ex     divider busy, asks the controller to stall
//   data_sram_*     data RAM request
//   ex_to_mem_bus   108-bit result bus towards MEM
// Modports: master = surrounding pipeline, slave = ex.
interface ex_if;
    logic [170:0] id_to_ex_bus;
    logic         br_e;
    logic [31:0]  br_addr;
    logic         stallreq_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [107:0] ex_to_mem_bus;

    modport master (
        output id_to_ex_bus,
        input  br_e, br_addr, stallreq_ex,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  ex_to_mem_bus
    );

    modport slave (
        input  id_to_ex_bus,
        output br_e, br_addr, stallreq_ex,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output ex_to_mem_bus
    );
endinterface

// File: rtl/ex.sv
// ex: execute stage of the five-stage MIPS pipeline.
// Latches id_to_ex_bus under stall/flush, computes the ALU result, resolves
// branches/jumps, issues the data-SRAM request and builds ex_to_mem_bus.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   i_flush  clears the EX register
//   i_stall  stall vector (bit 3 holds EX, bit 4 holds MEM; 1 = stop)
//   bus      ex_if.slave bundle (ID bus in, branch/SRAM/MEM outputs)
// Build option: define EX_DIV_EN to build the iterative DIV/DIVU unit with
// HI/LO and MFHI/MFLO. Without it stallreq_ex is 0, DIV/DIVU do nothing and
// MFHI/MFLO return 0.
//
// Divider states:
//   state  | meaning
//   IDLE   | waiting; a latched DIV/DIVU loads operands and starts
//   RUN    | one restoring-division bit per cycle, 32 cycles
//   DONE   | HI/LO written; waits for EX to advance
module ex (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic [5:0] i_stall,
    ex_if.slave        bus
);
    localparam logic STOP = 1'b1;

    logic [170:0] r_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= '0;
        end else if (i_flush) begin
            r_ex <= '0;
        end else if (i_stall[3] == STOP && i_stall[4] != STOP) begin
            r_ex <= '0;
        end else if (i_stall[3] != STOP) begin
            r_ex <= bus.id_to_ex_bus;
        end
    end

    logic [11:0] w_br_op;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic [11:0] w_alu_op;
    logic [2:0]  w_sel1;
    logic [3:0]  w_sel2;
    logic        w_ram_en;
    logic [3:0]  w_ram_wen;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic        w_sel_rf_res;
    logic [31:0] w_rs;
    logic [31:0] w_rt;

    assign w_br_op      = r_ex[170:159];
    assign w_pc         = r_ex[158:127];
    assign w_inst       = r_ex[126:95];
    assign w_alu_op     = r_ex[94:83];
    assign w_sel1       = r_ex[82:80];
    assign w_sel2       = r_ex[79:76];
    assign w_ram_en     = r_ex[75];
    assign w_ram_wen    = r_ex[74:71];
    assign w_rf_we      = r_ex[70];
    assign w_rf_waddr   = r_ex[69:65];
    assign w_sel_rf_res = r_ex[64];
    assign w_rs         = r_ex[63:32];
    assign w_rt         = r_ex[31:0];

    logic [31:0] w_imm_sext;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [31:0] w_alu;

    assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};

    always_comb begin
        w_src1 = '0;
        if (w_sel1[0])      w_src1 = w_rs;
        else if (w_sel1[1]) w_src1 = w_pc;
        else if (w_sel1[2]) w_src1 = {27'b0, w_inst[10:6]};
    end

    always_comb begin
        w_src2 = '0;
        if (w_sel2[0])      w_src2 = w_rt;
        else if (w_sel2[1]) w_src2 = w_imm_sext;
        else if (w_sel2[2]) w_src2 = 32'd8;
        else if (w_sel2[3]) w_src2 = {16'b0, w_inst[15:0]};
    end

    always_comb begin
        w_alu = '0;
        if (w_alu_op[0])       w_alu = w_src1 + w_src2;
        else if (w_alu_op[1])  w_alu = w_src1 - w_src2;
        else if (w_alu_op[2])  w_alu = {31'b0, $signed(w_src1) < $signed(w_src2)};
        else if (w_alu_op[3])  w_alu = {31'b0, w_src1 < w_src2};
        else if (w_alu_op[4])  w_alu = w_src1 & w_src2;
        else if (w_alu_op[5])  w_alu = ~(w_src1 | w_src2);
        else if (w_alu_op[6])  w_alu = w_src1 | w_src2;
        else if (w_alu_op[7])  w_alu = w_src1 ^ w_src2;
        else if (w_alu_op[8])  w_alu = w_src2 << w_src1[4:0];
        else if (w_alu_op[9])  w_alu = w_src2 >> w_src1[4:0];
        else if (w_alu_op[10]) w_alu = $unsigned($signed(w_src2) >>> w_src1[4:0]);
        else if (w_alu_op[11]) w_alu = {w_src2[15:0], 16'b0};
    end

    logic [31:0] w_pc4;
    logic        w_rs_zero;
    logic        w_br_cond;
    logic        w_jump;

    assign w_pc4     = w_pc + 32'd4;
    assign w_rs_zero = (w_rs == 32'd0);
    assign w_br_cond = (w_br_op[0] &  (w_rs == w_rt))
                     | (w_br_op[1] &  (w_rs != w_rt))
                     | (w_br_op[2] & ~w_rs[31])
                     | (w_br_op[3] & ~w_rs[31] & ~w_rs_zero)
                     | (w_br_op[4] & (w_rs[31] | w_rs_zero))
                     | (w_br_op[5] &  w_rs[31])
                     | (w_br_op[6] & ~w_rs[31])
                     | (w_br_op[7] &  w_rs[31]);
    assign w_jump    = |w_br_op[11:8];

    assign bus.br_e = w_br_cond | w_jump;

    always_comb begin
        bus.br_addr = '0;
        if (w_br_op[10] | w_br_op[11])
            bus.br_addr = w_rs;
        else if (w_br_op[8] | w_br_op[9])
            bus.br_addr = {w_pc4[31:28], w_inst[25:0], 2'b00};
        else if (|w_br_op[7:0])
            bus.br_addr = w_pc4 + {w_imm_sext[29:0], 2'b00};
    end

    logic w_is_mfhi;
    logic w_is_mflo;
    assign w_is_mfhi = (w_inst[31:26] == 6'd0) && (w_inst[5:0] == 6'h10);
    assign w_is_mflo = (w_inst[31:26] == 6'd0) && (w_inst[5:0] == 6'h12);

    logic [31:0] w_result;

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

    div_state_t  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_dvs;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_div;
    logic        w_div_sgn;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [32:0] w_diff;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic        w_last;

    assign w_is_div  = (w_inst[31:26] == 6'd0) && (w_inst[5:1] == 5'b01101);
    assign w_div_sgn = ~w_inst[0];

    // Restoring step: a zero divisor always "fits", giving all-ones quotient
    // and remainder = dividend without any special casing.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_rem_nx = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_nx = {r_quo[30:0], w_ge};
    assign w_last   = (r_state == S_RUN) && (r_cnt == 6'd1);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_is_div) begin
                    r_cnt   <= 6'd32;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == 6'd1) r_state <= S_DONE;
                    else               r_cnt   <= r_cnt - 6'd1;
                end
                S_DONE: if (i_stall[3] != STOP) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_is_div) begin
            r_quo   <= (w_div_sgn && w_rs[31]) ? (~w_rs + 32'd1) : w_rs;
            r_dvs   <= (w_div_sgn && w_rt[31]) ? (~w_rt + 32'd1) : w_rt;
            r_rem   <= '0;
            r_q_neg <= w_div_sgn & (w_rs[31] ^ w_rt[31]);
            r_r_neg <= w_div_sgn & w_rs[31];
        end else if (r_state == S_RUN) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
        end
    end

    // HI/LO survive reset and flush; only a completed division writes them.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_last) begin
            r_lo <= r_q_neg ? (~w_quo_nx + 32'd1) : w_quo_nx;
            r_hi <= r_r_neg ? (~w_rem_nx + 32'd1) : w_rem_nx;
        end
    end

    assign bus.stallreq_ex = (r_state == S_RUN) || (r_state == S_IDLE && w_is_div);

    always_comb begin
        w_result = w_alu;
        if (w_is_mfhi)      w_result = r_hi;
        else if (w_is_mflo) w_result = r_lo;
    end
`else
    assign bus.stallreq_ex = 1'b0;

    always_comb begin
        w_result = w_alu;
        if (w_is_mfhi || w_is_mflo) w_result = '0;
    end
`endif

    assign bus.data_sram_en    = w_ram_en;
    assign bus.data_sram_wen   = w_ram_wen;
    assign bus.data_sram_addr  = w_alu;
    assign bus.data_sram_wdata = w_rt;

    assign bus.ex_to_mem_bus = {w_pc, w_inst, w_ram_en, w_ram_wen, w_sel_rf_res,
                                w_rf_we, w_rf_waddr, w_result};
endmodule

// File: tb/tb_ex.sv
module tb_ex;
    typedef struct packed {
        logic [11:0] br_op;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic        en;
        logic [3:0]  wen;
        logic        rf_we;
        logic [4:0]  waddr;
        logic        sel;
        logic [31:0] rs;
        logic [31:0] rt;
    } op_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [5:0] stall = 6'b0;

    ex_if u_if();

    ex dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_stall (stall),
        .bus     (u_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx(input logic [11:0] v);
        for (int i = 0; i < 12; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_alu(input op_t o);
        logic [31:0] a, b;
        int sh;
        a = 0; b = 0;
        case (o.s1)
            3'b001: a = o.rs;
            3'b010: a = o.pc;
            3'b100: a = 32'(o.inst[10:6]);
            default: a = 0;
        endcase
        case (o.s2)
            4'b0001: b = o.rt;
            4'b0010: b = 32'($signed(o.inst[15:0]));
            4'b0100: b = 8;
            4'b1000: b = 32'(o.inst[15:0]);
            default: b = 0;
        endcase
        sh = int'(a % 32);
        case (idx(o.alu_op))
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 1 : 0;
            3:  return (a < b) ? 1 : 0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << sh;
            9:  return b >> sh;
            10: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            11: return b * 32'h10000;
            default: return 0;
        endcase
    endfunction

    function automatic logic m_br_e(input op_t o);
        int signed r;
        r = o.rs;
        case (idx(o.br_op))
            0: return o.rs == o.rt;
            1: return o.rs != o.rt;
            2, 6: return r >= 0;
            3: return r > 0;
            4: return r <= 0;
            5, 7: return r < 0;
            8, 9, 10, 11: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_br_addr(input op_t o);
        logic [31:0] pc4;
        pc4 = o.pc + 4;
        case (idx(o.br_op))
            -1: return 0;
            8, 9: return (pc4 & 32'hF000_0000) | ((o.inst & 32'h03FF_FFFF) * 4);
            10, 11: return o.rs;
            default: return pc4 + 32'($signed(o.inst[15:0]) * 4);
        endcase
    endfunction

    function automatic logic [107:0] m_mem(input op_t o, input logic [31:0] res);
        return {o.pc, o.inst, o.en, o.wen, o.sel, o.rf_we, o.waddr, res};
    endfunction

    task automatic check_op(input op_t o, input string tag);
        chk({tag, ".mem"},   u_if.ex_to_mem_bus, m_mem(o, m_alu(o)));
        chk({tag, ".br_e"},  u_if.br_e,          m_br_e(o));
        chk({tag, ".br_a"},  u_if.br_addr,       m_br_addr(o));
        chk({tag, ".addr"},  u_if.data_sram_addr, m_alu(o));
        chk({tag, ".wdata"}, u_if.data_sram_wdata, o.rt);
        chk({tag, ".en"},    {u_if.data_sram_en, u_if.data_sram_wen}, {o.en, o.wen});
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.br_op  = ($urandom_range(0, 2) == 0) ? 12'h0 : 12'(1 << $urandom_range(0, 11));
        o.pc     = $urandom & 32'hFFFF_FFFC;
        o.inst   = $urandom;
        o.inst[31:26] = 6'($urandom_range(1, 63));
        o.alu_op = 12'(1 << $urandom_range(0, 11));
        o.s1     = 3'(1 << $urandom_range(0, 2));
        o.s2     = 4'(1 << $urandom_range(0, 3));
        o.en     = 1'($urandom);
        o.wen    = 4'($urandom);
        o.rf_we  = 1'($urandom);
        o.waddr  = 5'($urandom);
        o.sel    = 1'($urandom);
        o.rs     = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
        o.rt     = ($urandom_range(0, 3) == 0) ? o.rs : $urandom;
        return o;
    endfunction

    task automatic m_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] ua, ub, q, r;
        ua = (sgn && a[31]) ? -a : a;
        ub = (sgn && b[31]) ? -b : b;
        q  = (ub == 0) ? 32'hFFFF_FFFF : ua / ub;
        r  = (ub == 0) ? ua : ua % ub;
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        m_lo = q;
        m_hi = r;
    endtask

    task automatic read_hilo(input string tag);
        op_t o;
        o = '0;
        o.inst = 32'h0000_0012;
        u_if.id_to_ex_bus = o;
        stall = 6'b0;
        step();
        chk({tag, ".mflo"}, u_if.ex_to_mem_bus[31:0], m_lo);
        o.inst = 32'h0000_0010;
        u_if.id_to_ex_bus = o;
        step();
        chk({tag, ".mfhi"}, u_if.ex_to_mem_bus[31:0], m_hi);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           input string tag);
        op_t o;
        int n;
        int exp_n;
        o = '0;
        o.inst = sgn ? 32'h0000_001A : 32'h0000_001B;
        o.rs = a;
        o.rt = b;
        n = 0;
`ifdef EX_DIV_EN
        exp_n = 33;
        m_div(a, b, sgn);
`else
        exp_n = 0;
`endif
        u_if.id_to_ex_bus = o;
        stall = 6'b0;
        step();
        while (u_if.stallreq_ex === 1'b1 && n < 100) begin
            n++;
            stall = 6'b011111;
            step();
        end
        chk({tag, ".stall_cycles"}, n, exp_n);
        read_hilo(tag);
    endtask

    initial begin
        op_t o, b;
        int n;
        u_if.id_to_ex_bus = 171'($urandom);
        // reset
        step();
        step();
        chk("rst.mem",   u_if.ex_to_mem_bus, '0);
        chk("rst.br",    {u_if.br_e, u_if.br_addr}, '0);
        chk("rst.stall", {u_if.stallreq_ex, u_if.data_sram_en}, '0);
        rst = 1'b0;

        // addiu-style overflow wrap
        o = '0; o.rs = 32'h7FFF_FFFF; o.inst = 32'h2400_0001;
        o.alu_op = 12'h001; o.s1 = 3'b001; o.s2 = 4'b0010; o.rf_we = 1'b1;
        u_if.id_to_ex_bus = o;
        step();
        chk("addiu.res", u_if.ex_to_mem_bus[31:0], 32'h8000_0000);
        check_op(o, "addiu");

        // beq taken then not taken
        o = '0; o.br_op = 12'h001; o.pc = 32'h1000; o.inst = 32'h1000_FFFF;
        o.rs = 5; o.rt = 5;
        u_if.id_to_ex_bus = o;
        step();
        chk("beq.taken", {u_if.br_e, u_if.br_addr}, {1'b1, 32'h0000_1000});
        o.rt = 6;
        u_if.id_to_ex_bus = o;
        step();
        chk("beq.not", u_if.br_e, 1'b0);

        // jal with link through the ALU
        o = '0; o.br_op = 12'h200; o.pc = 32'hBFC0_0010; o.inst = 32'h0C00_0100;
        o.alu_op = 12'h001; o.s1 = 3'b010; o.s2 = 4'b0100; o.rf_we = 1'b1; o.waddr = 5'd31;
        u_if.id_to_ex_bus = o;
        step();
        chk("jal.addr", {u_if.br_e, u_if.br_addr}, {1'b1, 32'hB000_0400});
        chk("jal.res",  u_if.ex_to_mem_bus[31:0], 32'hBFC0_0018);
        chk("jal.rfwe", {u_if.ex_to_mem_bus[37:32]}, {1'b1, 5'd31});

        // stall: bubble, then hold
        o = rand_op(); b = rand_op();
        u_if.id_to_ex_bus = o; stall = 6'b0;
        step();
        check_op(o, "pre_bubble");
        u_if.id_to_ex_bus = b; stall = 6'b001111;
        step();
        chk("bubble.mem", u_if.ex_to_mem_bus, '0);
        chk("bubble.br",  {u_if.br_e, u_if.data_sram_en}, '0);
        u_if.id_to_ex_bus = o; stall = 6'b0;
        step();
        u_if.id_to_ex_bus = b; stall = 6'b011111;
        step();
        step();
        check_op(o, "hold");
        stall = 6'b0;
        step();
        check_op(b, "release");

        // flush
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.mem", u_if.ex_to_mem_bus, '0);

        // randomized ALU/branch traffic
        for (int i = 0; i < 40; i++) begin
            o = rand_op();
            u_if.id_to_ex_bus = o;
            step();
            check_op(o, $sformatf("rnd%0d", i));
        end

        // divider
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
        run_div(32'hFFFF_FFF0, 32'd3, 1'b0, "divu_big");
        run_div(32'd100, 32'hFFFF_FFF9, 1'b1, "div_pos_neg");
        run_div(32'hFFFF_FFF9, 32'd0, 1'b1, "div_by0");
        run_div(32'd1234, 32'd0, 1'b0, "divu_by0");
        for (int i = 0; i < 4; i++)
            run_div($urandom, $urandom, 1'($urandom), $sformatf("div_rnd%0d", i));
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_again");

        // flush in the middle of a division keeps HI/LO
        o = '0; o.inst = 32'h0000_001B; o.rs = 100; o.rt = 7;
        u_if.id_to_ex_bus = o; stall = 6'b0;
        step();
        n = 0;
        while (n < 10) begin
            n++;
            stall = 6'b011111;
            step();
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("div_flush.stallreq", u_if.stallreq_ex, 1'b0);
        read_hilo("div_flush");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
